// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================
// Module : dmem_responder_if
// Desc   : request/response bus between an initiator and dmem_responder
// Rev    : 1.0
// ============================================================
interface dmem_responder_if #(
  parameter int DWIDTH = 32
);
  logic              dr_i_req_valid;
  logic              dr_o_req_ready;
  logic              dr_i_we;
  logic [3:0]        dr_i_mask;
  logic [31:0]       dr_i_addr;
  logic [DWIDTH-1:0] dr_i_wdata;
  logic              dr_o_rsp_valid;
  logic              dr_i_rsp_ready;
  logic [DWIDTH-1:0] dr_o_rdata;
  logic              dr_o_err;

  modport master (
    output dr_i_req_valid, dr_i_we, dr_i_mask, dr_i_addr, dr_i_wdata, dr_i_rsp_ready,
    input  dr_o_req_ready, dr_o_rsp_valid, dr_o_rdata, dr_o_err
  );

  modport slave (
    input  dr_i_req_valid, dr_i_we, dr_i_mask, dr_i_addr, dr_i_wdata, dr_i_rsp_ready,
    output dr_o_req_ready, dr_o_rsp_valid, dr_o_rdata, dr_o_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================
// Module : dmem_responder
// Desc   : word-wide data memory responder with fixed wait states
// Rev    : 1.0
// ============================================================
module dmem_responder #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic       dr_clk,
  input  wire logic       dr_rst,
  dmem_responder_if.slave bus
);
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_WAIT   = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;
  localparam int         c_LANES     = 4;
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_ready_en;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [3:0]            r_mask;
  logic [31:0]           r_addr;
  logic [DWIDTH-1:0]     r_wdata;
  logic [DWIDTH-1:0]     r_rdata;
  logic                  r_err;
  logic [DWIDTH-1:0]     r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_accept;
  logic                  w_exec;
  logic                  w_addr_err;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_accept   = bus.dr_i_req_valid && w_req_ready;
  assign w_exec     = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
  assign w_idx      = r_addr[DEPTH_LOG2+1:2];
  assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr[31:DEPTH_LOG2+2] != '0);

  assign bus.dr_o_req_ready = w_req_ready;
  assign bus.dr_o_rsp_valid = w_rsp_valid;
  assign bus.dr_o_rdata     = r_rdata;
  assign bus.dr_o_err       = r_err;

  always_ff @(posedge dr_clk or negedge dr_rst) begin
    if (!dr_rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = c_ST_RESP;
      c_ST_RESP: if (bus.dr_i_rsp_ready) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Ready is held low until the first edge after reset release.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      c_ST_IDLE: w_req_ready = r_ready_en;
      c_ST_RESP: w_rsp_valid = 1'b1;
      default: begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dr_clk or negedge dr_rst) begin
    if (!dr_rst) begin
      r_ready_en <= 1'b0;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_mask     <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_we    <= bus.dr_i_we;
        r_mask  <= bus.dr_i_mask;
        r_addr  <= bus.dr_i_addr;
        r_wdata <= bus.dr_i_wdata;
        r_cnt   <= c_WAIT_INIT;
      end else if ((r_state == c_ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_exec) begin
        if (w_addr_err) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else if (r_we) begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end else begin
          r_rdata <= r_mem[w_idx];
          r_err   <= 1'b0;
        end
      end else if (w_rsp_valid && bus.dr_i_rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain; an aborted store never reaches w_exec.
  always_ff @(posedge dr_clk) begin
    if (w_exec && r_we && !w_addr_err) begin
      for (int l = 0; l < c_LANES; l++) begin
        if (r_mask[l]) begin
          r_mem[w_idx][l*8 +: 8] <= r_wdata[l*8 +: 8];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Scoreboarded random and directed bench for dmem_responder.
module tb_dmem_responder;
  localparam int WAIT = 2;

  typedef struct {
    bit          we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } req_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   n_checks;
  int   n_fail;
  int   rr_force;
  req_t sbq[$];
  logic [31:0] model [0:31];
  logic [31:0] last_rdata;
  logic        last_err;
  bit          prev_valid;

  dmem_responder_if #(.DWIDTH(32)) bus ();
  dmem_responder_if #(.DWIDTH(32)) bus0 ();

  dmem_responder #(.DWIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WAIT)) dut (
    .dr_clk (clk),
    .dr_rst (rst_n),
    .bus    (bus.slave)
  );

  dmem_responder #(.DWIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .dr_clk (clk),
    .dr_rst (rst_n),
    .bus    (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, got no response expected one", name);
  endtask

  task automatic do_req(input bit we, input logic [3:0] mask, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_t r;
    bit   acc;
    int   n;
    @(posedge clk); #1;
    bus.dr_i_req_valid = 1'b1;
    bus.dr_i_we        = we;
    bus.dr_i_mask      = mask;
    bus.dr_i_addr      = addr;
    bus.dr_i_wdata     = wdata;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.dr_o_req_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      fail_timeout("accept");
    end else begin
      r.we = we; r.mask = mask; r.addr = addr; r.wdata = wdata; r.acc = cycle;
      sbq.push_back(r);
    end
    // Post-acceptance input changes must be ignored.
    bus.dr_i_req_valid = 1'b0;
    bus.dr_i_we        = 1'($urandom);
    bus.dr_i_mask      = 4'($urandom);
    bus.dr_i_addr      = $urandom;
    bus.dr_i_wdata     = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_timeout("drain");
    @(posedge clk); #1;
  endtask

  // Monitor: reference results are derived from the model when the response appears.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      prev_valid = 1'b0;
    end else if (bus.dr_o_rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_rsp_valid", 1, 0);
      end else begin
        req_t        r;
        bit          e;
        logic [31:0] exp_rd;
        r      = sbq[0];
        e      = (r.addr % 4 != 0) || (r.addr >= 32'd4096);
        exp_rd = 32'd0;
        if (!e && !r.we) exp_rd = model[r.addr / 4];
        chk("rsp_rdata", bus.dr_o_rdata, exp_rd);
        chk("rsp_err", bus.dr_o_err, e);
        chk("req_ready_in_resp", bus.dr_o_req_ready, 0);
        if (!prev_valid) chk("latency", cycle - r.acc, WAIT + 1);
        if (bus.dr_i_rsp_ready) begin
          if (!e && r.we) begin
            for (int l = 0; l < 4; l++) begin
              if (r.mask[l]) model[r.addr / 4][l*8 +: 8] = r.wdata[l*8 +: 8];
            end
          end
          last_rdata = bus.dr_o_rdata;
          last_err   = bus.dr_o_err;
          void'(sbq.pop_front());
        end
      end
      prev_valid = bus.dr_o_rsp_valid && !bus.dr_i_rsp_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    bus.dr_i_rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_force < 0) bus.dr_i_rsp_ready = ($urandom_range(0, 2) != 0);
      else              bus.dr_i_rsp_ready = rr_force[0];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] old20;
    int          n;
    bit          seen;
    n_checks = 0; n_fail = 0; cycle = 0; rr_force = -1;
    prev_valid = 1'b0; last_rdata = '0; last_err = 1'b0;
    rst_n = 1'b0;
    bus.dr_i_req_valid = 0; bus.dr_i_we = 0; bus.dr_i_mask = 0; bus.dr_i_addr = 0; bus.dr_i_wdata = 0;
    bus0.dr_i_req_valid = 0; bus0.dr_i_we = 0; bus0.dr_i_mask = 0; bus0.dr_i_addr = 0;
    bus0.dr_i_wdata = 0; bus0.dr_i_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.dr_o_req_ready, 0);
    chk("rst_rsp_valid", bus.dr_o_rsp_valid, 0);
    chk("rst_rdata", bus.dr_o_rdata, 0);
    chk("rst_err", bus.dr_o_err, 0);
    chk("rst_req_ready_w0", bus0.dr_o_req_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.dr_o_req_ready, 1);
    chk("ready_after_rst_w0", bus0.dr_o_req_ready, 1);

    // Zero-wait instance: response must be visible right after the first edge.
    bus0.dr_i_req_valid = 1; bus0.dr_i_we = 1; bus0.dr_i_mask = 4'hF; bus0.dr_i_wdata = 32'h5;
    @(negedge clk);
    chk("w0_ready", bus0.dr_o_req_ready, 1);
    @(posedge clk); #1;
    bus0.dr_i_req_valid = 0;
    chk("w0_valid_at_n", bus0.dr_o_rsp_valid, 0);
    @(posedge clk); #1;
    chk("w0_valid_at_n1", bus0.dr_o_rsp_valid, 1);
    chk("w0_err", bus0.dr_o_err, 0);
    @(posedge clk); #1;
    chk("w0_valid_done", bus0.dr_o_rsp_valid, 0);

    for (int i = 0; i < 32; i++) do_req(1'b1, 4'hF, 32'(i * 4), $urandom);
    wait_idle();

    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 4'h0, 32'h10, 32'h0);
    wait_idle();
    chk("store_load_full", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 4'b0001, 32'h10, 32'h000000AA);
    do_req(1'b0, 4'h3, 32'h10, 32'hFFFFFFFF);
    wait_idle();
    chk("store_lane0", last_rdata, 32'hDEADBEAA);

    w0 = model[0];
    do_req(1'b0, 4'hF, 32'h13, 32'h0);
    wait_idle();
    chk("misaligned_err", last_err, 1);
    do_req(1'b1, 4'hF, 32'h00001000, 32'h12345678);
    wait_idle();
    chk("range_err", last_err, 1);
    chk("range_rdata", last_rdata, 0);
    do_req(1'b0, 4'hF, 32'h0, 32'h0);
    wait_idle();
    chk("word0_kept", last_rdata, w0);
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    wait_idle();
    chk("word4_kept", last_rdata, 32'hDEADBEAA);

    // Backpressure: response must hold for five cycles.
    rr_force = 0;
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = bus.dr_o_rsp_valid;
      n++;
    end
    if (!seen) fail_timeout("hold_rsp");
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("hold_valid", bus.dr_o_rsp_valid, 1);
      chk("hold_rdata", bus.dr_o_rdata, 32'hDEADBEAA);
      chk("hold_err", bus.dr_o_err, 0);
      chk("hold_ready", bus.dr_o_req_ready, 0);
    end
    rr_force = 1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("hs_valid_before", bus.dr_o_rsp_valid, 1);
    @(negedge clk);
    chk("hs_valid_after", bus.dr_o_rsp_valid, 0);
    rr_force = -1;
    wait_idle();

    // Reset while a store is waiting must abort it.
    old20 = model[8];
    do_req(1'b1, 4'hF, 32'h20, ~old20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", bus.dr_o_req_ready, 0);
    chk("abort_rsp_valid", bus.dr_o_rsp_valid, 0);
    chk("abort_rdata", bus.dr_o_rdata, 0);
    chk("abort_err", bus.dr_o_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_abort", bus.dr_o_req_ready, 1);
    do_req(1'b0, 4'hF, 32'h20, 32'h0);
    wait_idle();
    chk("aborted_store_absent", last_rdata, old20);

    for (int i = 0; i < 150; i++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      if (k == 0)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (k == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, 31) * 4);
      do_req(1'($urandom), 4'($urandom), a, $urandom);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
